ahb_regs: RTL and testbench
===========================

AHB_REGS -- requirements
Module: ahb_regs

Interface
REQ-001 SHALL have port: HCLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: HRESETn  in  1  reset; synchronous, active-high (asserted = 1, sampled on HCLK rise).
REQ-003 SHALL have AHB slave inputs: HSELx 1, HADDR 32, HBURST 3, HPROT 4, HSIZE 3, HTRANS 2, HWRITE 1, HWDATA 32.
REQ-004 SHALL have FIFO status inputs: rcv_fifo_full 1, rcv_fifo_empty 1, tx_fifo_empty 1; and tx_word in 32 (head of tx FIFO).
REQ-005 SHALL have strobe outputs, 1 bit each: rcv_enq_word (HWDATA enqueued to rcv FIFO), tx_deq_word (pop tx FIFO), key_in (HWDATA is a key word), is_encrypt_pulse, is_decrypt_pulse, is_status (status read).
REQ-006 SHALL have AHB outputs: HRDATA 32, HREADY 1, HRESP 2 (00 OKAY, 01 ERROR).

Function
REQ-007 Address phase SHALL be accepted when HSELx=1, HTRANS is NONSEQ(10) or SEQ(11) and HREADY=1; IDLE/BUSY SHALL cause no access.
REQ-008 Accepted HADDR/HWRITE SHALL be registered; strobes and data phase SHALL occur in the following cycle.
REQ-009 Address map (word, HADDR[11:0]): 0x00 status R; 0x04 encrypt cmd W; 0x08 decrypt cmd W; 0x10-0x1C key W; 0x20-0x2C input data W; 0x30-0x3C output data R.
REQ-010 Write 0x04 / 0x08 SHALL assert is_encrypt_pulse / is_decrypt_pulse for exactly one cycle in the data phase.
REQ-011 Write to 0x10-0x1C SHALL assert key_in for one cycle per beat in its data phase (HWDATA valid); 4-beat INCR burst gives 4 consecutive key_in cycles.
REQ-012 Write to 0x20-0x2C SHALL assert rcv_enq_word in data phase when rcv_fifo_full=0.
REQ-013 Read of 0x30-0x3C SHALL drive HRDATA=tx_word and assert tx_deq_word in data phase when tx_fifo_empty=0.
REQ-014 Read of 0x00 SHALL drive HRDATA={29'b0, rcv_fifo_full, rcv_fifo_empty, tx_fifo_empty} and assert is_status one cycle.
REQ-015 Unmapped address, wrong direction (read of W-only, write of R-only), or HSIZE≠2 SHALL give two-cycle ERROR: cycle 1 HREADY=0 HRESP=01; cycle 2 HREADY=1 HRESP=01; no strobes.
REQ-016 FSM states: IDLE, DATA, ERR1, ERR2, WAIT; ERR1→ERR2→IDLE/DATA per next accepted transfer.
REQ-017 HRDATA SHALL be 0 outside read data phases; HPROT, HBURST SHALL be ignored.
REQ-018 Non-accepted cycles SHALL leave HREADY=1, HRESP=00.

Reset
REQ-019 While HRESETn=1 at clock edge: FSM→IDLE, HREADY=1, HRESP=00, HRDATA=0, all strobes 0; reset mid-burst or mid-error SHALL abort with no strobes.

Configuration
REQ-020 Macro AHB_REGS_FIFO_WAIT_EN defined: input write with rcv_fifo_full=1 or output read with tx_fifo_empty=1 SHALL hold HREADY=0 (WAIT) until condition clears, then complete with strobe.
REQ-021 Macro undefined: those same accesses SHALL get the two-cycle ERROR response of REQ-015, no strobe.

Verification
REQ-022 Reset: HRESETn=1 two cycles -> HREADY=1, HRESP=00, all strobes 0.
REQ-023 NONSEQ write HADDR=0x128 -> next cycle HREADY=0 HRESP=01; following cycle HREADY=1 HRESP=01; then OKAY.
REQ-024 SINGLE NONSEQ write HADDR=0x08 -> is_decrypt_pulse=1 next cycle only; same with 0x04 -> is_encrypt_pulse=1.
REQ-025 INCR write 0x10,0x14,0x18,0x1C with HWDATA 0x00112233..0xCCDDEEFF -> key_in high 4 consecutive cycles aligned with each word.
REQ-026 Read 0x00 with rcv_fifo_empty=1, tx_fifo_empty=1 -> HRDATA=0x3, is_status=1 one cycle.
REQ-027 Read 0x30 with tx_fifo_empty=1 -> WAIT (macro on) until empty=0 then HRDATA=tx_word, tx_deq_word=1; macro off -> ERROR pair.

Source files
------------

// File: rtl/ahb_regs.sv
// AHB-Lite register slave for the cipher block: command pulses, key and data FIFO ports, status reads.
// Latency: the strobe and HRDATA appear one cycle after the accepted address phase. A bad access gets a 2-cycle ERROR.
// Backpressure: HREADY is low in ERR1. When AHB_REGS_FIFO_WAIT_EN is defined, HREADY is also low while a FIFO is blocked.
module ahb_regs (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        rcv_fifo_full,
  input  logic        rcv_fifo_empty,
  input  logic        tx_fifo_empty,
  input  logic [31:0] tx_word,
  output logic        rcv_enq_word,
  output logic        tx_deq_word,
  output logic        key_in,
  output logic        is_encrypt_pulse,
  output logic        is_decrypt_pulse,
  output logic        is_status,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_ERR1 = 3'd2;
  localparam logic [2:0] S_ERR2 = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  // Register classes. K_NONE marks an address that is not in the map.
  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_STAT = 3'd1;
  localparam logic [2:0] K_ENC  = 3'd2;
  localparam logic [2:0] K_DEC  = 3'd3;
  localparam logic [2:0] K_KEY  = 3'd4;
  localparam logic [2:0] K_IN   = 3'd5;
  localparam logic [2:0] K_OUT  = 3'd6;

  logic [2:0] r_state;
  logic [2:0] r_kind;
  logic [2:0] w_next_state;
  logic [2:0] w_kind;
  logic       w_accept;
  logic       w_bad;
  logic       w_blocked_addr;
  logic       w_blocked_wait;
  logic       w_data;

  // The bus fields that carry no meaning for this slave. The write data goes directly to the FIFO or key logic outside this block.
  wire w_unused = ^{HBURST, HPROT, HADDR[31:12], HWDATA};

  assign w_accept = HSELx && HTRANS[1] && HREADY;

  // Decode the address in the address phase. Direction and size errors are detected here, before the data phase.
  always_comb begin
    w_kind = K_NONE;
    if (HADDR[1:0] == 2'b00) begin
      if (HADDR[11:0] == 12'h000)      w_kind = K_STAT;
      else if (HADDR[11:0] == 12'h004) w_kind = K_ENC;
      else if (HADDR[11:0] == 12'h008) w_kind = K_DEC;
      else if (HADDR[11:4] == 8'h01)   w_kind = K_KEY;
      else if (HADDR[11:4] == 8'h02)   w_kind = K_IN;
      else if (HADDR[11:4] == 8'h03)   w_kind = K_OUT;
    end
    w_bad = (w_kind == K_NONE) || (HSIZE != 3'b010) ||
            (((w_kind == K_STAT) || (w_kind == K_OUT)) ? HWRITE : !HWRITE);
    w_blocked_addr = ((w_kind == K_IN) && rcv_fifo_full) || ((w_kind == K_OUT) && tx_fifo_empty);
    w_blocked_wait = ((r_kind == K_IN) && rcv_fifo_full) || ((r_kind == K_OUT) && tx_fifo_empty);
  end

  // Next-state logic. A new transfer can only be accepted in a state that drives HREADY high.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (w_accept) begin
          if (w_bad)
            w_next_state = S_ERR1;
          else if (w_blocked_addr)
`ifdef AHB_REGS_FIFO_WAIT_EN
            w_next_state = S_WAIT;
`else
            w_next_state = S_ERR1;
`endif
          else
            w_next_state = S_DATA;
        end
      end
      S_ERR1:  w_next_state = S_ERR2;
      S_WAIT:  w_next_state = w_blocked_wait ? S_WAIT : S_DATA;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and registered address-phase decode. Reset drops any transfer that is in progress.
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      r_state <= S_IDLE;
      r_kind  <= K_NONE;
    end else begin
      r_state <= w_next_state;
      if (w_accept) r_kind <= w_kind;
    end
  end

  assign w_data           = (r_state == S_DATA);
  assign HREADY           = !((r_state == S_ERR1) || (r_state == S_WAIT));
  assign HRESP            = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign rcv_enq_word     = w_data && (r_kind == K_IN);
  assign tx_deq_word      = w_data && (r_kind == K_OUT);
  assign key_in           = w_data && (r_kind == K_KEY);
  assign is_encrypt_pulse = w_data && (r_kind == K_ENC);
  assign is_decrypt_pulse = w_data && (r_kind == K_DEC);
  assign is_status        = w_data && (r_kind == K_STAT);

  // Read data mux. HRDATA is zero outside a completing read data phase.
  always_comb begin
    HRDATA = 32'h0;
    if (w_data && (r_kind == K_STAT))
      HRDATA = {29'b0, rcv_fifo_full, rcv_fifo_empty, tx_fifo_empty};
    else if (w_data && (r_kind == K_OUT))
      HRDATA = tx_word;
  end

endmodule

// File: tb/tb_ahb_regs.sv
// Directed bench for ahb_regs: it drives one step per clock and checks each output with an immediate assertion.
// The expected values are hand-derived. The FIFO-blocked cases follow AHB_REGS_FIFO_WAIT_EN.
// The bench drives inputs 1 ns after the rising edge and samples outputs 1 ns after that.
module tb_ahb_regs;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELx;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        rcv_fifo_full;
  logic        rcv_fifo_empty;
  logic        tx_fifo_empty;
  logic [31:0] tx_word;
  logic        rcv_enq_word, tx_deq_word, key_in;
  logic        is_encrypt_pulse, is_decrypt_pulse, is_status;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  int n_vec = 0;
  int n_bad = 0;

  ahb_regs dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR),
    .HBURST(HBURST), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .rcv_fifo_full(rcv_fifo_full),
    .rcv_fifo_empty(rcv_fifo_empty), .tx_fifo_empty(tx_fifo_empty),
    .tx_word(tx_word), .rcv_enq_word(rcv_enq_word), .tx_deq_word(tx_deq_word),
    .key_in(key_in), .is_encrypt_pulse(is_encrypt_pulse),
    .is_decrypt_pulse(is_decrypt_pulse), .is_status(is_status),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [31:0] addr, input logic [2:0] size);
    HSELx  = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic idle_bus();
    bus(1'b0, T_IDLE, 1'b0, 32'h0, 3'b010);
  endtask

  // The strobe order is {rcv_enq_word, tx_deq_word, key_in, is_encrypt_pulse, is_decrypt_pulse, is_status}.
  task automatic expect_out(input string tag, input logic rdy, input logic [1:0] resp,
                            input logic [5:0] stb, input logic [31:0] rdata);
    #1;
    chk({tag, ".hready"}, {31'b0, HREADY}, {31'b0, rdy});
    chk({tag, ".hresp"},  {30'b0, HRESP},  {30'b0, resp});
    chk({tag, ".strobes"},
        {26'b0, rcv_enq_word, tx_deq_word, key_in, is_encrypt_pulse, is_decrypt_pulse, is_status},
        {26'b0, stb});
    chk({tag, ".hrdata"}, HRDATA, rdata);
  endtask

  initial begin
    HRESETn = 1'b1; idle_bus();
    HBURST = 3'b000; HPROT = 4'h3; HWDATA = 32'h0;
    rcv_fifo_full = 1'b0; rcv_fifo_empty = 1'b1; tx_fifo_empty = 1'b1; tx_word = 32'h0;

    // Hold reset for two cycles.
    cyc(); cyc();
    expect_out("reset", 1'b1, 2'b00, 6'b000000, 32'h0);
    HRESETn = 1'b0;

    // Unmapped write: ERROR pair, then OKAY.
    cyc(); bus(1'b1, T_NSEQ, 1'b1, 32'h128, 3'b010);
    cyc(); idle_bus();
    expect_out("unmap.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    cyc(); expect_out("unmap.e2", 1'b1, 2'b01, 6'b000000, 32'h0);
    cyc(); expect_out("unmap.ok", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Decrypt and encrypt command pulses, each exactly one cycle.
    bus(1'b1, T_NSEQ, 1'b1, 32'h08, 3'b010);
    cyc(); idle_bus(); expect_out("dec", 1'b1, 2'b00, 6'b000010, 32'h0);
    cyc(); expect_out("dec.end", 1'b1, 2'b00, 6'b000000, 32'h0);
    bus(1'b1, T_NSEQ, 1'b1, 32'h04, 3'b010);
    cyc(); idle_bus(); expect_out("enc", 1'b1, 2'b00, 6'b000100, 32'h0);
    cyc(); expect_out("enc.end", 1'b1, 2'b00, 6'b000000, 32'h0);

    // INCR4 key burst: key_in is high for four cycles, one per data beat.
    HBURST = 3'b011;
    bus(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b010);
    cyc(); bus(1'b1, T_SEQ, 1'b1, 32'h14, 3'b010); HWDATA = 32'h00112233;
    expect_out("key0", 1'b1, 2'b00, 6'b001000, 32'h0);
    cyc(); bus(1'b1, T_SEQ, 1'b1, 32'h18, 3'b010); HWDATA = 32'h44556677;
    expect_out("key1", 1'b1, 2'b00, 6'b001000, 32'h0);
    cyc(); bus(1'b1, T_SEQ, 1'b1, 32'h1C, 3'b010); HWDATA = 32'h8899AABB;
    expect_out("key2", 1'b1, 2'b00, 6'b001000, 32'h0);
    cyc(); idle_bus(); HWDATA = 32'hCCDDEEFF;
    expect_out("key3", 1'b1, 2'b00, 6'b001000, 32'h0);
    cyc(); HBURST = 3'b000;
    expect_out("key.end", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Status read with both FIFOs empty.
    bus(1'b1, T_NSEQ, 1'b0, 32'h00, 3'b010);
    cyc(); idle_bus(); expect_out("status", 1'b1, 2'b00, 6'b000001, 32'h3);
    cyc(); expect_out("status.end", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Output read while the tx FIFO is empty.
    tx_word = 32'hDEADBEEF;
    bus(1'b1, T_NSEQ, 1'b0, 32'h30, 3'b010);
    cyc(); idle_bus();
`ifdef AHB_REGS_FIFO_WAIT_EN
    expect_out("txw.w0", 1'b0, 2'b00, 6'b000000, 32'h0);
    cyc(); expect_out("txw.w1", 1'b0, 2'b00, 6'b000000, 32'h0);
    tx_fifo_empty = 1'b0;
    cyc(); expect_out("txw.data", 1'b1, 2'b00, 6'b010000, 32'hDEADBEEF);
`else
    expect_out("txe.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    cyc(); expect_out("txe.e2", 1'b1, 2'b01, 6'b000000, 32'h0);
    tx_fifo_empty = 1'b0;
`endif
    cyc(); expect_out("tx.end", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Output read with data available.
    tx_word = 32'h12345678;
    bus(1'b1, T_NSEQ, 1'b0, 32'h34, 3'b010);
    cyc(); idle_bus(); expect_out("txrd", 1'b1, 2'b00, 6'b010000, 32'h12345678);

    // Input write while the rcv FIFO has room.
    bus(1'b1, T_NSEQ, 1'b1, 32'h20, 3'b010);
    cyc(); idle_bus(); expect_out("enq", 1'b1, 2'b00, 6'b100000, 32'h0);

    // Input write while the rcv FIFO is full.
    rcv_fifo_full = 1'b1;
    bus(1'b1, T_NSEQ, 1'b1, 32'h24, 3'b010);
    cyc(); idle_bus();
`ifdef AHB_REGS_FIFO_WAIT_EN
    expect_out("rcvw.w0", 1'b0, 2'b00, 6'b000000, 32'h0);
    rcv_fifo_full = 1'b0;
    cyc(); expect_out("rcvw.data", 1'b1, 2'b00, 6'b100000, 32'h0);
`else
    expect_out("rcvf.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    rcv_fifo_full = 1'b0;
    cyc(); expect_out("rcvf.e2", 1'b1, 2'b01, 6'b000000, 32'h0);
`endif
    cyc(); expect_out("rcv.end", 1'b1, 2'b00, 6'b000000, 32'h0);

    // A wrong-direction read of the encrypt command is an error.
    bus(1'b1, T_NSEQ, 1'b0, 32'h04, 3'b010);
    cyc(); idle_bus(); expect_out("wdir.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    cyc(); expect_out("wdir.e2", 1'b1, 2'b01, 6'b000000, 32'h0);

    // A halfword access to a key register is an error.
    bus(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b001);
    cyc(); idle_bus(); expect_out("hsize.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    cyc(); expect_out("hsize.e2", 1'b1, 2'b01, 6'b000000, 32'h0);

    // A deselected slave and BUSY transfers cause no access.
    cyc(); bus(1'b0, T_NSEQ, 1'b1, 32'h04, 3'b010);
    cyc(); bus(1'b1, T_BUSY, 1'b1, 32'h04, 3'b010);
    expect_out("nosel", 1'b1, 2'b00, 6'b000000, 32'h0);
    cyc(); idle_bus(); expect_out("busy", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Reset during the error response aborts it.
    bus(1'b1, T_NSEQ, 1'b1, 32'h00, 3'b010);
    cyc(); idle_bus(); expect_out("rsterr.e1", 1'b0, 2'b01, 6'b000000, 32'h0);
    HRESETn = 1'b1;
    cyc(); HRESETn = 1'b0; expect_out("rsterr", 1'b1, 2'b00, 6'b000000, 32'h0);

    // Reset in the middle of a burst drops the remaining beats.
    bus(1'b1, T_NSEQ, 1'b1, 32'h10, 3'b010);
    cyc(); bus(1'b1, T_SEQ, 1'b1, 32'h14, 3'b010); HRESETn = 1'b1;
    expect_out("rstb.k0", 1'b1, 2'b00, 6'b001000, 32'h0);
    cyc(); bus(1'b1, T_SEQ, 1'b1, 32'h18, 3'b010);
    expect_out("rstb.abort", 1'b1, 2'b00, 6'b000000, 32'h0);
    HRESETn = 1'b0; idle_bus();
    cyc(); expect_out("rstb.idle", 1'b1, 2'b00, 6'b000000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
